// File: rtl/voice_mixer.sv
// voice_mixer: time-multiplexed 16-voice mixer for the wavetable path.
// A sample tick snapshots all voice samples, volumes and enables, then one
// signed multiply-accumulate runs per clock. The sum is scaled down,
// re-biased to offset-binary and clamped into a 12-bit DAC sample.
module voice_mixer #(
    parameter int VOICES = 16,
    parameter int SHIFT  = 4,
    parameter int DATA_W = 12,
    parameter int COEF_W = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       sample_tick,
    input  logic [DATA_W*VOICES-1:0]   voice_values,
    input  logic [COEF_W*VOICES-1:0]   voice_volume,
    input  logic [VOICES-1:0]          voice_enable,
    output logic [DATA_W-1:0]          sample_out,
    output logic                       sample_valid,
    output logic                       busy,
    output logic                       overrun
);

    localparam int IDX_W  = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int ACC_W  = 16;
    localparam int PROD_W = 9 + COEF_W + 1;
    localparam int SUM_W  = ACC_W + 1;
    localparam int MID    = 2 ** (DATA_W - 1);
    localparam int FULL   = (2 ** DATA_W) - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_OUTPUT
    } state_t;

    state_t                     state;
    logic [IDX_W-1:0]           idx_p1;
    logic signed [ACC_W-1:0]    acc_p1;

    logic [8*VOICES-1:0]        vals_p0;
    logic [COEF_W*VOICES-1:0]   vols_p0;
    logic [VOICES-1:0]          en_p0;

    logic [7:0]                 cur_val;
    logic [COEF_W-1:0]          cur_vol;
    logic                       cur_en;
    logic signed [PROD_W-1:0]   term_c;
    logic                       start;

    // Only the low byte of each voice sample carries audio; the top nibble
    // is deliberately discarded.
    logic [(DATA_W-8)*VOICES-1:0] hi_unused;
    logic                         hi_unused_x;

    // Signed voice contribution: byte re-centred to -128..127, scaled by volume.
    function automatic logic signed [PROD_W-1:0] voice_term(
        input logic [7:0]        v,
        input logic [COEF_W-1:0] vol,
        input logic              en
    );
        logic signed [8:0] s;
        s = $signed({1'b0, v}) - 9'sd128;
        return en ? PROD_W'(s) * PROD_W'($signed({1'b0, vol})) : '0;
    endfunction

    // Scale the sum, re-bias to offset-binary and clamp to the DAC range.
    function automatic logic [DATA_W-1:0] rebias_sat(
        input logic signed [ACC_W-1:0] acc
    );
        logic signed [SUM_W-1:0] r;
        r = SUM_W'(acc >>> SHIFT) + SUM_W'(MID);
        if (r < 0)
            return '0;
        if (r > SUM_W'(FULL))
            return '1;
        return r[DATA_W-1:0];
    endfunction

    // Gather the ignored upper sample bits so they are visibly intentional.
    for (genvar v = 0; v < VOICES; v++) begin : g_hi
        assign hi_unused[(DATA_W-8)*v +: (DATA_W-8)] = voice_values[DATA_W*v+8 +: (DATA_W-8)];
    end
    assign hi_unused_x = ^hi_unused;

    // A frame starts only from idle and not in the cycle the last result is shown.
    assign start = (state == S_IDLE) && sample_tick && !sample_valid;

    // Select the voice addressed by the running index from the snapshot.
    always_comb begin
        cur_val = vals_p0[int'(idx_p1)*8 +: 8];
        cur_vol = vols_p0[int'(idx_p1)*COEF_W +: COEF_W];
        cur_en  = en_p0[idx_p1];
        term_c  = voice_term(cur_val, cur_vol, cur_en);
    end

    // Stage p0: capture frame inputs at the tick so later changes cannot leak in.
    always_ff @(posedge CLK) begin
        if (start) begin
            for (int v = 0; v < VOICES; v++)
                vals_p0[8*v +: 8] <= voice_values[DATA_W*v +: 8];
            vols_p0 <= voice_volume;
            en_p0   <= voice_enable;
        end
    end

    // Stage p1: frame sequencing, accumulation and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= S_IDLE;
            idx_p1       <= '0;
            acc_p1       <= '0;
            sample_out   <= DATA_W'(MID);
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc_p1 <= '0;
                        idx_p1 <= '0;
                        busy   <= 1'b1;
                        state  <= S_ACCUM;
                    end else if (sample_tick) begin
                        overrun <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    overrun <= sample_tick;
                    acc_p1  <= acc_p1 + ACC_W'(term_c);
                    if (idx_p1 == IDX_W'(VOICES - 1))
                        state <= S_OUTPUT;
                    else
                        idx_p1 <= idx_p1 + 1'b1;
                end
                S_OUTPUT: begin
                    overrun      <= sample_tick;
                    sample_out   <= rebias_sat(acc_p1);
                    sample_valid <= 1'b1;
                    busy         <= 1'b0;
                    idx_p1       <= '0;
                    state        <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: randomized scoreboard bench for voice_mixer.
// Two instances (default shift and shift 2) share stimulus; expected samples
// come from a plain-arithmetic model of the mixing rule.
module tb_voice_mixer;

    localparam int NV = 16;

    logic                CLK;
    logic                RST;
    logic                sample_tick;
    logic [12*NV-1:0]    voice_values;
    logic [4*NV-1:0]     voice_volume;
    logic [NV-1:0]       voice_enable;

    logic [11:0]         so4, so2;
    logic                sv4, sv2, busy4, busy2, ov4, ov2;

    voice_mixer dut4 (
        .CLK(CLK), .RST(RST), .sample_tick(sample_tick),
        .voice_values(voice_values), .voice_volume(voice_volume),
        .voice_enable(voice_enable), .sample_out(so4),
        .sample_valid(sv4), .busy(busy4), .overrun(ov4)
    );

    voice_mixer #(.SHIFT(2)) dut2 (
        .CLK(CLK), .RST(RST), .sample_tick(sample_tick),
        .voice_values(voice_values), .voice_volume(voice_volume),
        .voice_enable(voice_enable), .sample_out(so2),
        .sample_valid(sv2), .busy(busy2), .overrun(ov2)
    );

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t q4[$];
    exp_t q2[$];
    int   oq[$];

    int   vals[NV];
    int   vols[NV];
    bit   en[NV];

    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Mixing rule: centred low byte times volume, summed, floor-scaled, re-biased, clamped.
    function automatic int mix(input int sh);
        int sum;
        int r;
        sum = 0;
        for (int v = 0; v < NV; v++)
            if (en[v])
                sum += ((vals[v] % 256) - 128) * vols[v];
        r = (sum >>> sh) + 2048;
        if (r < 0) r = 0;
        if (r > 4095) r = 4095;
        return r;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pack();
        for (int v = 0; v < NV; v++) begin
            voice_values[12*v +: 12] = 12'(vals[v]);
            voice_volume[4*v +: 4]   = 4'(vols[v]);
            voice_enable[v]          = en[v];
        end
    endtask

    task automatic set_all(input int val, input int vol, input bit e);
        for (int v = 0; v < NV; v++) begin
            vals[v] = val;
            vols[v] = vol;
            en[v]   = e;
        end
    endtask

    task automatic randomize_stim();
        for (int v = 0; v < NV; v++) begin
            case ($urandom_range(0, 3))
                0:       vals[v] = 12'h0FF | ($urandom_range(0, 15) << 8);
                1:       vals[v] = $urandom_range(0, 15) << 8;
                default: vals[v] = $urandom_range(0, 4095);
            endcase
            vols[v] = $urandom_range(0, 15);
            en[v]   = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic do_tick(input bit expect_result);
        if (expect_result) begin
            q4.push_back('{mix(4), cyc + 18});
            q2.push_back('{mix(2), cyc + 18});
        end
        sample_tick = 1'b1;
    endtask

    // One full frame; optionally scramble the inputs while it runs.
    task automatic run_frame(input int extra, input bit scramble);
        int t;
        pack();
        do_tick(1'b1);
        t = cyc;
        for (int n = 1; n <= 18 + extra; n++) begin
            step();
            sample_tick = 1'b0;
            if (scramble)
                for (int v = 0; v < NV; v++) begin
                    voice_values[12*v +: 12] = 12'($urandom_range(0, 4095));
                    voice_volume[4*v +: 4]   = 4'($urandom_range(0, 15));
                end
            @(negedge CLK);
            chk("busy", int'(busy4), int'(n <= 17));
        end
    endtask

    // Scoreboard monitor for the default-shift instance.
    always @(negedge CLK) begin
        if (sv4 === 1'b1) begin
            if (q4.size() == 0) begin
                chk("spurious_valid4", int'(sv4), 0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk("sample4", int'(so4), e.val);
                chk("latency4", cyc, e.cyc);
            end
        end
        if (ov4 === 1'b1) begin
            if (oq.size() == 0)
                chk("spurious_overrun", int'(ov4), 0);
            else
                chk("overrun_cycle", cyc, oq.pop_front());
        end
    end

    // Scoreboard monitor for the shift-2 instance.
    always @(negedge CLK) begin
        if (sv2 === 1'b1) begin
            if (q2.size() == 0) begin
                chk("spurious_valid2", int'(sv2), 0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("sample2", int'(so2), e.val);
                chk("latency2", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end

    initial begin
        int t;
        RST          = 1'b1;
        sample_tick  = 1'b0;
        voice_values = '0;
        voice_volume = '0;
        voice_enable = '0;
        step();
        step();
        @(negedge CLK);
        chk("rst_sample_out", int'(so4), 2048);
        chk("rst_valid", int'(sv4), 0);
        chk("rst_busy", int'(busy4), 0);
        chk("rst_overrun", int'(ov4), 0);
        RST = 1'b0;
        step();

        // Silence.
        set_all(12'h080, 15, 1'b1);
        run_frame(2, 1'b0);

        // Single voice polarity and ignored upper bits.
        set_all(12'h080, 15, 1'b0);
        en[0] = 1'b1;
        vals[0] = 12'h0FF; run_frame(1, 1'b0);
        vals[0] = 12'h000; run_frame(1, 1'b0);
        vals[0] = 12'hF80; run_frame(1, 1'b0);

        // Full scale both polarities (shift-2 instance clamps high).
        set_all(12'h0FF, 15, 1'b1); run_frame(1, 1'b0);
        set_all(12'h000, 15, 1'b1); run_frame(1, 1'b0);

        // Isolation, overrun while busy, and tick on the result cycle.
        randomize_stim();
        pack();
        do_tick(1'b1);
        t = cyc;
        step(); sample_tick = 1'b0;
        step(); step();
        voice_values = '0;
        step(); step();
        oq.push_back(cyc + 1);
        sample_tick = 1'b1;
        step(); sample_tick = 1'b0;
        while (cyc < t + 18) step();
        oq.push_back(cyc + 1);
        sample_tick = 1'b1;
        step(); sample_tick = 1'b0;
        @(negedge CLK);
        chk("tick_on_valid_ignored", int'(busy4), 0);
        step(); step();

        // Reset in the middle of a frame.
        randomize_stim();
        pack();
        do_tick(1'b0);
        t = cyc;
        step(); sample_tick = 1'b0;
        while (cyc < t + 8) step();
        RST = 1'b1;
        step();
        @(negedge CLK);
        chk("midrst_busy", int'(busy4), 0);
        chk("midrst_sample_out", int'(so4), 2048);
        chk("midrst_busy2", int'(busy2), 0);
        RST = 1'b0;
        step();
        randomize_stim();
        run_frame(1, 1'b1);

        // Randomized frames with inputs scrambled during accumulation.
        for (int k = 0; k < 30; k++) begin
            randomize_stim();
            run_frame($urandom_range(1, 4), 1'b1);
        end

        for (int n = 0; n < 25; n++) step();
        chk("q4_drained", q4.size(), 0);
        chk("q2_drained", q2.size(), 0);
        chk("oq_drained", oq.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
